// File: rtl/hazard_unit_pkg.sv
// Shared pipeline constants for the hazard unit: Hi/Lo timer state encoding,
// default mult/div latencies and the hard-wired zero register.
package hazard_unit_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int MULT_LAT_DEF = 4;
    localparam int DIV_LAT_DEF  = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a producer writing regAddr feeds an operand the ID instruction reads.
    // $0 never creates a dependency because writes to it are discarded.
    function automatic logic regMatch(
        input logic [4:0] regAddr,
        input logic       usesRs,
        input logic [4:0] rsAddr,
        input logic       usesRt,
        input logic [4:0] rtAddr
    );
        return (regAddr != REG_ZERO) &&
               ((usesRs && (regAddr == rsAddr)) || (usesRt && (regAddr == rtAddr)));
    endfunction

endpackage

// File: rtl/hazard_unit_muldiv_timer.sv
// Hi/Lo occupancy timer: counts down the mult/div latency after an op enters EX.
// A start seen while already busy is ignored.
module muldiv_timer
    import hazard_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
    localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

    logic [0:0] state;
    logic [0:0] stateNext;
    logic [5:0] cnt;
    logic [5:0] cntNext;

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cntNext   = is_div ? DIV_CNT : MULT_CNT;
                    stateNext = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // Leaving on cnt==1 makes BUSY last exactly the loaded count.
                cntNext = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
                cntNext   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Masked by reset so the flag is quiet before the first reset edge too.
    assign busy = (state == ST_BUSY) && !reset;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard detection: load-use, ID-stage branch operand and Hi/Lo
// stalls, plus IF/ID flush for taken control transfers.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] IF_ID_RsAddr,
    input  logic [4:0] IF_ID_RtAddr,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       ID_Branch,
    input  logic       ID_BranchTaken,
    input  logic       ID_Jump,
    input  logic       ID_ReadsHiLo,
    input  logic       ID_IsMulDiv,
    input  logic       ID_EX_RegWr,
    input  logic [4:0] ID_EX_RegWrAddr,
    input  logic       ID_EX_MemRead,
    input  logic       ID_EX_MulDivStart,
    input  logic       ID_EX_IsDiv,
    input  logic       EX_MEM_MemRead,
    input  logic [4:0] EX_MEM_RegWrAddr,
    output logic       PC_Stall,
    output logic       IF_ID_Stall,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       MulDiv_Busy
);

    logic exMatch;
    logic memMatch;
    logic loadUse;
    logic brHazard;
    logic hiloHazard;
    logic stall;
    logic timerBusy;

    muldiv_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) uTimer (
        .clk    (clk),
        .reset  (reset),
        .start  (ID_EX_MulDivStart),
        .is_div (ID_EX_IsDiv),
        .busy   (timerBusy)
    );

    assign exMatch  = regMatch(ID_EX_RegWrAddr, ID_UsesRs, IF_ID_RsAddr, ID_UsesRt, IF_ID_RtAddr);
    assign memMatch = regMatch(EX_MEM_RegWrAddr, ID_UsesRs, IF_ID_RsAddr, ID_UsesRt, IF_ID_RtAddr);

    assign loadUse  = ID_EX_MemRead && exMatch;
    // Branches compare in ID, so any EX result or an in-flight load in MEM is too late.
    assign brHazard = ID_Branch && ((ID_EX_RegWr && exMatch) || (EX_MEM_MemRead && memMatch));
    assign hiloHazard = (ID_ReadsHiLo || ID_IsMulDiv) && (timerBusy || ID_EX_MulDivStart);

    assign stall = (loadUse || brHazard || hiloHazard) && !reset;

    assign PC_Stall    = stall;
    assign IF_ID_Stall = stall;
    assign ID_EX_Flush = stall;
    // A stalled branch has stale operands, so its redirect waits for the retry.
    assign IF_ID_Flush = (ID_Jump || (ID_Branch && ID_BranchTaken)) && !stall && !reset;
    assign MulDiv_Busy = timerBusy;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: cycle-by-cycle model comparison plus
// hand-computed literal checks for each hazard scenario.
module tb_hazard_unit;

    localparam int M_LAT = 4;
    localparam int D_LAT = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] IF_ID_RsAddr, IF_ID_RtAddr;
    logic       ID_UsesRs, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump;
    logic       ID_ReadsHiLo, ID_IsMulDiv;
    logic       ID_EX_RegWr, ID_EX_MemRead, ID_EX_MulDivStart, ID_EX_IsDiv;
    logic [4:0] ID_EX_RegWrAddr, EX_MEM_RegWrAddr;
    logic       EX_MEM_MemRead;
    logic       PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush, MulDiv_Busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit done  = 1'b0;

    hazard_unit dut (
        .clk               (clk),
        .reset             (reset),
        .IF_ID_RsAddr      (IF_ID_RsAddr),
        .IF_ID_RtAddr      (IF_ID_RtAddr),
        .ID_UsesRs         (ID_UsesRs),
        .ID_UsesRt         (ID_UsesRt),
        .ID_Branch         (ID_Branch),
        .ID_BranchTaken    (ID_BranchTaken),
        .ID_Jump           (ID_Jump),
        .ID_ReadsHiLo      (ID_ReadsHiLo),
        .ID_IsMulDiv       (ID_IsMulDiv),
        .ID_EX_RegWr       (ID_EX_RegWr),
        .ID_EX_RegWrAddr   (ID_EX_RegWrAddr),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_MulDivStart (ID_EX_MulDivStart),
        .ID_EX_IsDiv       (ID_EX_IsDiv),
        .EX_MEM_MemRead    (EX_MEM_MemRead),
        .EX_MEM_RegWrAddr  (EX_MEM_RegWrAddr),
        .PC_Stall          (PC_Stall),
        .IF_ID_Stall       (IF_ID_Stall),
        .IF_ID_Flush       (IF_ID_Flush),
        .ID_EX_Flush       (ID_EX_Flush),
        .MulDiv_Busy       (MulDiv_Busy)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Hi/Lo busy is tracked as a window of absolute cycle numbers [win_lo, win_hi].
    int cyc    = 0;
    int win_lo = 1;
    int win_hi = 0;

    function automatic bit dep(input logic [4:0] a);
        return (a != 5'd0) && ((ID_UsesRs && a == IF_ID_RsAddr) || (ID_UsesRt && a == IF_ID_RtAddr));
    endfunction

    always begin
        @(negedge clk);
        if (!done) begin
            bit m_busy, m_stall, m_flush;
            m_busy  = !reset && (cyc >= win_lo) && (cyc <= win_hi);
            m_stall = !reset && (
                        (ID_EX_MemRead && dep(ID_EX_RegWrAddr)) ||
                        (ID_Branch && ((ID_EX_RegWr && dep(ID_EX_RegWrAddr)) ||
                                       (EX_MEM_MemRead && dep(EX_MEM_RegWrAddr)))) ||
                        ((ID_ReadsHiLo || ID_IsMulDiv) && (m_busy || ID_EX_MulDivStart)));
            m_flush = !reset && !m_stall && (ID_Jump || (ID_Branch && ID_BranchTaken));
            check("model_PC_Stall", PC_Stall, m_stall);
            check("model_IF_ID_Stall", IF_ID_Stall, m_stall);
            check("model_ID_EX_Flush", ID_EX_Flush, m_stall);
            check("model_IF_ID_Flush", IF_ID_Flush, m_flush);
            check("model_MulDiv_Busy", MulDiv_Busy, m_busy);
            assert (reset || !(ID_EX_MulDivStart && m_busy))
                else $error("protocol: mul/div start while Hi/Lo busy");
            if (reset) begin
                win_lo = 1;
                win_hi = 0;
            end else if (ID_EX_MulDivStart && !m_busy) begin
                win_lo = cyc + 1;
                win_hi = cyc + (ID_EX_IsDiv ? D_LAT : M_LAT);
            end
            cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        IF_ID_RsAddr = 5'd0; IF_ID_RtAddr = 5'd0;
        ID_UsesRs = 0; ID_UsesRt = 0; ID_Branch = 0; ID_BranchTaken = 0; ID_Jump = 0;
        ID_ReadsHiLo = 0; ID_IsMulDiv = 0;
        ID_EX_RegWr = 0; ID_EX_RegWrAddr = 5'd0; ID_EX_MemRead = 0;
        ID_EX_MulDivStart = 0; ID_EX_IsDiv = 0;
        EX_MEM_MemRead = 0; EX_MEM_RegWrAddr = 5'd0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int stall_cnt, busy_cnt;
        reset = 1'b1;
        idle_inputs();
        ID_Jump = 1; ID_ReadsHiLo = 1; ID_EX_MulDivStart = 1;
        ID_EX_MemRead = 1; ID_EX_RegWrAddr = 5'd3; ID_UsesRs = 1; IF_ID_RsAddr = 5'd3;
        #2;
        check("reset_flush", IF_ID_Flush, 1'b0);
        check("reset_stall", PC_Stall, 1'b0);
        check("reset_busy", MulDiv_Busy, 1'b0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        next_cycle();
        check("idle_busy", MulDiv_Busy, 1'b0);

        // lw $t0 in EX, add reading $t0 in ID
        ID_EX_MemRead = 1; ID_EX_RegWr = 1; ID_EX_RegWrAddr = 5'd8;
        ID_UsesRs = 1; IF_ID_RsAddr = 5'd8; ID_UsesRt = 1; IF_ID_RtAddr = 5'd10;
        #1;
        check("loaduse_stall", PC_Stall, 1'b1);
        check("loaduse_bubble", ID_EX_Flush, 1'b1);
        next_cycle();
        ID_EX_MemRead = 0; ID_EX_RegWr = 0; ID_EX_RegWrAddr = 5'd0;
        #1;
        check("loaduse_release", PC_Stall, 1'b0);

        // beq on $t1 while EX writes $t1, then retry with hazard gone
        next_cycle();
        idle_inputs();
        ID_Branch = 1; ID_BranchTaken = 1; ID_UsesRs = 1; IF_ID_RsAddr = 5'd4;
        ID_UsesRt = 1; IF_ID_RtAddr = 5'd9; ID_EX_RegWr = 1; ID_EX_RegWrAddr = 5'd9;
        #1;
        check("branch_stall", IF_ID_Stall, 1'b1);
        check("branch_noflush", IF_ID_Flush, 1'b0);
        next_cycle();
        ID_EX_RegWr = 0; ID_EX_RegWrAddr = 5'd0;
        #1;
        check("branch_flush", IF_ID_Flush, 1'b1);
        check("branch_nostall", PC_Stall, 1'b0);

        // branch waiting on a load in MEM
        next_cycle();
        idle_inputs();
        ID_Branch = 1; ID_UsesRs = 1; IF_ID_RsAddr = 5'd12;
        EX_MEM_MemRead = 1; EX_MEM_RegWrAddr = 5'd12;
        #1;
        check("branch_memload_stall", PC_Stall, 1'b1);

        // load to $0 never stalls; unused operand field never stalls
        next_cycle();
        idle_inputs();
        ID_EX_MemRead = 1; ID_EX_RegWrAddr = 5'd0; ID_UsesRs = 1; IF_ID_RsAddr = 5'd0;
        #1;
        check("zero_reg_nostall", PC_Stall, 1'b0);
        next_cycle();
        ID_EX_RegWrAddr = 5'd7; ID_UsesRs = 0; IF_ID_RsAddr = 5'd7;
        #1;
        check("unused_rs_nostall", PC_Stall, 1'b0);

        // jump with no hazard
        next_cycle();
        idle_inputs();
        ID_Jump = 1;
        #1;
        check("jump_flush", IF_ID_Flush, 1'b1);
        check("jump_nostall", PC_Stall, 1'b0);

        // div enters EX with mflo in ID: stall 1+32 cycles, busy 32
        next_cycle();
        idle_inputs();
        ID_EX_MulDivStart = 1; ID_EX_IsDiv = 1; ID_ReadsHiLo = 1;
        #1;
        check("div_start_stall", PC_Stall, 1'b1);
        check("div_start_notbusy", MulDiv_Busy, 1'b0);
        stall_cnt = 1;
        busy_cnt  = 0;
        for (int i = 1; i <= 40; i++) begin
            next_cycle();
            ID_EX_MulDivStart = 0; ID_EX_IsDiv = 0;
            #1;
            if (PC_Stall) stall_cnt++;
            if (MulDiv_Busy) busy_cnt++;
            if (i == 32) check("div_last_busy", MulDiv_Busy, 1'b1);
            if (i == 33) begin
                check("div_stall_drop", PC_Stall, 1'b0);
                check("div_busy_drop", MulDiv_Busy, 1'b0);
            end
        end
        n_cmp++;
        if (stall_cnt != 33) begin
            n_bad++;
            $display("FAIL div_stall_count: got %0d expected 33", stall_cnt);
        end
        n_cmp++;
        if (busy_cnt != 32) begin
            n_bad++;
            $display("FAIL div_busy_count: got %0d expected 32", busy_cnt);
        end

        // mult followed by a reset on BUSY cycle 2
        next_cycle();
        idle_inputs();
        ID_EX_MulDivStart = 1;
        next_cycle();
        ID_EX_MulDivStart = 0; ID_IsMulDiv = 1;
        #1;
        check("mult_busy1", MulDiv_Busy, 1'b1);
        check("mult_stall1", PC_Stall, 1'b1);
        next_cycle();
        reset = 1'b1;
        #1;
        check("mult_reset_busy", MulDiv_Busy, 1'b0);
        check("mult_reset_stall", PC_Stall, 1'b0);
        next_cycle();
        reset = 1'b0;
        ID_IsMulDiv = 0; ID_ReadsHiLo = 1;
        #1;
        check("mult_after_reset_busy", MulDiv_Busy, 1'b0);
        check("mult_after_reset_stall", PC_Stall, 1'b0);
        for (int i = 0; i < 4; i++) next_cycle();

        // mult latency with mfhi waiting in ID
        idle_inputs();
        ID_EX_MulDivStart = 1; ID_IsMulDiv = 1;
        next_cycle();
        ID_EX_MulDivStart = 0; ID_IsMulDiv = 0; ID_ReadsHiLo = 1;
        for (int i = 0; i < 6; i++) next_cycle();
        idle_inputs();
        next_cycle();

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter MULT_LAT, default 4, cycles Hi/Lo stay busy after a mult enters EX (legal range 2..63).
REQ-002 SHALL have parameter DIV_LAT, default 32, cycles Hi/Lo stay busy after a div enters EX (legal range 2..63).
REQ-003 SHALL use one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
REQ-004 SHALL have these inputs:
- IF_ID_RsAddr  in  5  Rs of the instruction in ID.
- IF_ID_RtAddr  in  5  Rt of the instruction in ID.
- ID_UsesRs  in  1  ID instruction reads Rs.
- ID_UsesRt  in  1  ID instruction reads Rt.
- ID_Branch  in  1  ID instruction is a conditional branch, compared in ID.
- ID_BranchTaken  in  1  ID comparator result.
- ID_Jump  in  1  ID instruction is j/jal/jr/jalr.
- ID_ReadsHiLo  in  1  ID instruction is mfhi/mflo/mthi/mtlo.
- ID_IsMulDiv  in  1  ID instruction is mult/multu/div/divu.
- ID_EX_RegWr  in  1  EX instruction writes a register.
- ID_EX_RegWrAddr  in  5  EX destination.
- ID_EX_MemRead  in  1  EX instruction is a load.
- ID_EX_MulDivStart  in  1  mult/div is in EX this cycle.
- ID_EX_IsDiv  in  1  qualifies ID_EX_MulDivStart: 1 = div, 0 = mult.
- EX_MEM_MemRead  in  1  MEM instruction is a load.
- EX_MEM_RegWrAddr  in  5  MEM destination.
REQ-005 SHALL have these outputs:
- PC_Stall  out  1  hold PC.
- IF_ID_Stall  out  1  hold IF/ID register.
- IF_ID_Flush  out  1  zero IF/ID register.
- ID_EX_Flush  out  1  insert bubble into ID/EX.
- MulDiv_Busy  out  1  Hi/Lo timer active; registered.

Function
REQ-006 SHALL define match(A) as A != 0 and ((ID_UsesRs and A == IF_ID_RsAddr) or (ID_UsesRt and A == IF_ID_RtAddr)).
REQ-007 SHALL raise load_use when ID_EX_MemRead and match(ID_EX_RegWrAddr).
REQ-008 SHALL raise br_hazard when ID_Branch and either (ID_EX_RegWr and match(ID_EX_RegWrAddr)) or (EX_MEM_MemRead and match(EX_MEM_RegWrAddr)).
REQ-009 SHALL raise hilo_hazard when (ID_ReadsHiLo or ID_IsMulDiv) and (MulDiv_Busy or ID_EX_MulDivStart).
REQ-010 SHALL set stall = load_use or br_hazard or hilo_hazard.
REQ-011 SHALL drive PC_Stall = IF_ID_Stall = ID_EX_Flush = stall, combinationally in the same cycle.
REQ-012 SHALL drive IF_ID_Flush = (ID_Jump or (ID_Branch and ID_BranchTaken)) and not stall; stall wins because ID operands are not yet valid.
REQ-013 SHALL implement an FSM with states IDLE and BUSY, plus a 6-bit down-counter cnt.
REQ-014 SHALL, in IDLE with ID_EX_MulDivStart=1, load cnt with DIV_LAT (ID_EX_IsDiv=1) or MULT_LAT (ID_EX_IsDiv=0) and move to BUSY at the next edge.
REQ-015 SHALL, in BUSY, decrement cnt each cycle and return to IDLE at the edge where cnt==1, so BUSY lasts exactly LAT cycles.
REQ-016 SHALL ignore ID_EX_MulDivStart while in BUSY (protocol violation, flagged by a bench assertion).
REQ-017 SHALL drive MulDiv_Busy = (state == BUSY).
REQ-018 SHALL stall a mult/div and a Hi/Lo access that arrive together for the full latency: a start in EX blocks a Hi/Lo access in ID that cycle, and MulDiv_Busy blocks it for the following LAT cycles.

Reset
REQ-019 SHALL, at any edge with reset=1, force state=IDLE and cnt=0, including mid-BUSY.
REQ-020 SHALL hold PC_Stall, IF_ID_Stall, IF_ID_Flush, ID_EX_Flush and MulDiv_Busy at 0 while reset is high, regardless of other inputs.

Structure
REQ-021 SHALL place the state encoding (IDLE=0, BUSY=1), the MULT_LAT/DIV_LAT defaults and the REG_ZERO=5'd0 constant in the shared pipeline package.
REQ-022 SHALL isolate the FSM and counter in one sub-module, muldiv_timer (ports clk, reset, start, is_div, busy); hazard_unit instantiates it and keeps all remaining logic combinational.

Verification
REQ-023 SHALL cover: lw $t0 in EX (ID_EX_RegWrAddr=8) with add using Rs=8 in ID -> stall=1 for one cycle, ID_EX_Flush=1, then 0.
REQ-024 SHALL cover: beq in ID with Rt=9, ID_EX_RegWr=1 and addr 9 -> stall=1 and IF_ID_Flush=0 although ID_BranchTaken=1; next cycle, with the hazard cleared, IF_ID_Flush=1.
REQ-025 SHALL cover: a load to $0 in EX with Rs=0 in ID -> no stall.
REQ-026 SHALL cover: div enters EX (IsDiv=1) and mflo is in ID the same cycle -> stall=1 on that cycle plus 32 more; MulDiv_Busy high exactly 32 cycles; stall drops on cycle 33.
REQ-027 SHALL cover: mult starts, then reset is pulsed at BUSY cycle 2 -> MulDiv_Busy=0 the cycle after the reset edge; no stall afterwards.
REQ-028 SHALL cover: j in ID with no hazard -> IF_ID_Flush=1 and PC_Stall=0 in the same cycle.
